pc_fetch_unit: RTL and testbench

Program-counter and instruction-fetch sequencer that sits directly downstream of the delay counter. It consumes `pcEn` as its advance permission, holds the program counter, and issues request/acknowledge fetches to instruction memory. It applies taken branches and flags fetches that time out.

---
 rtl/pc_fetch_unit_if.sv | 14 +
 rtl/pc_fetch_unit.sv | 102 ++++++++++
 tb/tb_pc_fetch_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Request/acknowledge instruction-memory bus between the fetch unit (master)
// and instruction memory (slave).
interface pc_fetch_unit_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
);
  logic                   memReq;
  logic [PC_WIDTH-1:0]    memAddr;
  logic                   memAck;
  logic [INSTR_WIDTH-1:0] memData;

  modport master (output memReq, memAddr, input memAck, memData);
  modport slave  (input memReq, memAddr, output memAck, memData);
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and request/acknowledge fetch sequencer with branch latch
// and sticky fetch-timeout flag. All outputs are registered.
module pc_fetch_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int RESET_PC    = 0,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pcEn,
  input  logic                   branchValid,
  input  logic [PC_WIDTH-1:0]    branchTarget,
  pc_fetch_unit_if.master        mem,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instrValid,
  output logic                   fetchErr
);

  typedef enum logic [1:0] {IDLE, FETCH, ADVANCE} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t              state;
  logic                mem_req;
  logic [7:0]          wait_cnt;
  logic                pend_valid;
  logic [PC_WIDTH-1:0] pend_target;
  logic [PC_WIDTH-1:0] next_pc;

  assign mem.memReq  = mem_req;
  assign mem.memAddr = pc;

  // A branch arriving on the advance edge beats the pending one.
  always_comb begin
    next_pc = pc + PC_WIDTH'(1);
    if (branchValid)     next_pc = branchTarget;
    else if (pend_valid) next_pc = pend_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= PC_WIDTH'(RESET_PC);
      mem_req     <= 1'b0;
      instr       <= '0;
      instrValid  <= 1'b0;
      fetchErr    <= 1'b0;
      wait_cnt    <= '0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      instrValid <= 1'b0;
      if (branchValid) begin
        pend_valid  <= 1'b1;
        pend_target <= branchTarget;
      end

      // NOTE: non-blocking assignments mean the last one in this block wins,
      // so consuming the pending branch below overrides the latch above.
      case (state)
        IDLE: begin
          if (pcEn) begin
            mem_req <= 1'b1;
            state   <= FETCH;
          end
        end

        FETCH: begin
          if (mem.memAck) begin
            instr      <= mem.memData;
            instrValid <= 1'b1;
            mem_req    <= 1'b0;
            wait_cnt   <= '0;
            state      <= ADVANCE;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            // Give up on this request; pc is kept so IDLE retries it.
            fetchErr <= 1'b1;
            mem_req  <= 1'b0;
            wait_cnt <= '0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        ADVANCE: begin
          if (pcEn) begin
            pc         <= next_pc;
            pend_valid <= 1'b0;
            mem_req    <= 1'b1;
            state      <= FETCH;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, stall, branches, wrap,
// ack/timeout race, timeout retry and reset in the middle of a fetch.
module tb_pc_fetch_unit;
  localparam int PW  = 8;
  localparam int IW  = 16;
  localparam int RPC = 'h10;
  localparam int TO  = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pcEn = 1'b0;
  logic          branchValid = 1'b0;
  logic [PW-1:0] branchTarget = '0;
  logic [PW-1:0] pc;
  logic [IW-1:0] instr;
  logic          instrValid;
  logic          fetchErr;

  int n_checks = 0;
  int n_fail   = 0;

  pc_fetch_unit_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) mem_bus ();

  pc_fetch_unit #(
    .PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(RPC), .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pcEn(pcEn), .branchValid(branchValid),
    .branchTarget(branchTarget), .mem(mem_bus), .pc(pc), .instr(instr),
    .instrValid(instrValid), .fetchErr(fetchErr)
  );

  always #5 clk = ~clk;

  // Memory model: the word at address a is 0x100 + a.
  assign mem_bus.memData = 16'h0100 + {8'h00, mem_bus.memAddr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_fetch(input string tag, input logic [31:0] addr);
    check({tag, "_req"},   mem_bus.memReq, 1);
    check({tag, "_addr"},  mem_bus.memAddr, addr);
    check({tag, "_pc"},    pc, addr);
    check({tag, "_valid"}, instrValid, 0);
  endtask

  task automatic expect_ack(input string tag, input logic [31:0] word);
    check({tag, "_valid"}, instrValid, 1);
    check({tag, "_instr"}, instr, word);
    check({tag, "_req"},   mem_bus.memReq, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_bus.memAck = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 'h10);
    check("rst_addr", mem_bus.memAddr, 'h10);
    check("rst_req", mem_bus.memReq, 0);
    check("rst_instr", instr, 0);
    check("rst_valid", instrValid, 0);
    check("rst_err", fetchErr, 0);

    // Sequential fetch with ack tied high: one instruction per two cycles.
    rst_n = 1'b1;
    pcEn = 1'b1;
    mem_bus.memAck = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); expect_fetch("seq_fetch", 'h10 + k);
      @(negedge clk); expect_ack("seq_ack", 'h110 + k);
    end

    // Stall five cycles in ADVANCE at 0x12.
    pcEn = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_pc", pc, 'h12);
      check("stall_req", mem_bus.memReq, 0);
    end
    pcEn = 1'b1;
    @(negedge clk); expect_fetch("stall_resume", 'h13);
    @(negedge clk); expect_ack("stall_ack", 'h113);

    // Branch to 0x05, then a branch to 0x40 while 0x05 waits 3 cycles for ack.
    branchValid = 1'b1; branchTarget = 8'h05;
    mem_bus.memAck = 1'b0;
    @(negedge clk); expect_fetch("br_fetch5", 'h05);
    branchTarget = 8'h40;
    @(negedge clk);
    branchValid = 1'b0;
    check("br_hold_addr", mem_bus.memAddr, 'h05);
    check("br_hold_req", mem_bus.memReq, 1);
    @(negedge clk);
    check("br_hold_addr2", mem_bus.memAddr, 'h05);
    mem_bus.memAck = 1'b1;
    @(negedge clk); expect_ack("br_ack5", 'h105);
    @(negedge clk); expect_fetch("br_fetch40", 'h40);
    @(negedge clk); expect_ack("br_ack40", 'h140);
    @(negedge clk); expect_fetch("br_fetch41", 'h41);
    @(negedge clk); expect_ack("br_ack41", 'h141);

    // Wrap-around from 0xFF.
    branchValid = 1'b1; branchTarget = 8'hFF;
    @(negedge clk);
    branchValid = 1'b0;
    expect_fetch("wrap_fetchff", 'hFF);
    @(negedge clk); expect_ack("wrap_ackff", 'h1FF);
    @(negedge clk); expect_fetch("wrap_fetch00", 'h00);
    @(negedge clk); expect_ack("wrap_ack00", 'h100);

    // Ack arriving on the very edge the timeout would fire: ack wins.
    mem_bus.memAck = 1'b0;
    @(negedge clk); expect_fetch("race_fetch", 'h01);
    repeat (TO - 1) @(negedge clk);
    mem_bus.memAck = 1'b1;
    @(negedge clk); expect_ack("race_ack", 'h101);
    check("race_err", fetchErr, 0);

    // Timeout: fetchErr rises TO cycles after memReq, then the same pc is retried.
    mem_bus.memAck = 1'b0;
    @(negedge clk); expect_fetch("to_fetch", 'h02);
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      check("to_wait_err", fetchErr, 0);
      check("to_wait_req", mem_bus.memReq, 1);
    end
    @(negedge clk);
    check("to_err", fetchErr, 1);
    check("to_req_drop", mem_bus.memReq, 0);
    check("to_pc", pc, 'h02);
    @(negedge clk); expect_fetch("to_retry", 'h02);
    mem_bus.memAck = 1'b1;
    @(negedge clk); expect_ack("to_retry_ack", 'h102);
    check("to_err_sticky", fetchErr, 1);
    @(negedge clk); expect_fetch("to_next", 'h03);
    check("to_err_sticky2", fetchErr, 1);

    // Reset in the middle of a fetch with a branch pending.
    mem_bus.memAck = 1'b0;
    branchValid = 1'b1; branchTarget = 8'h77;
    @(negedge clk);
    branchValid = 1'b0;
    check("mid_req", mem_bus.memReq, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req", mem_bus.memReq, 0);
    check("mid_rst_pc", pc, 'h10);
    check("mid_rst_addr", mem_bus.memAddr, 'h10);
    check("mid_rst_err", fetchErr, 0);
    check("mid_rst_valid", instrValid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_bus.memAck = 1'b1;
    @(negedge clk); expect_fetch("post_fetch", 'h10);
    @(negedge clk); expect_ack("post_ack", 'h110);
    @(negedge clk); expect_fetch("pend_discard", 'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
